// File: rtl/w_tile_fetch.sv
// -----------------------------------------------------------------------------
// w_tile_fetch
//   Read-side controller for the weight slice buffer. On start it requests
//   weight tiles one at a time (a single weight_read pulse per request),
//   captures each returned tile word and presents it to the PE array over a
//   valid/ready handshake. After the last tile of a group is consumed it pulses
//   we_valid_del so the slice buffer can refill. Once every group has been
//   delivered it pulses we_done. A request that goes unanswered for RETRY_GAP
//   cycles is re-issued.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   sudo_reset      soft clear, same effect as reset
//   start           begin a fetch sequence (only honoured while idle)
//   kernel          3 -> 1 tile per group, 6 -> 4 tiles per group, else error
//   num_groups      number of groups to fetch, 0 behaves as 1
//   weight_read     one-cycle request to the slice buffer
//   weight_data     tile word returned by the slice buffer
//   weight_valid    weight_data valid
//   we_valid_del    one-cycle pulse: group consumed, slice may refill
//   pe_w_data       tile word held toward the PE array
//   pe_w_valid      pe_w_data valid
//   pe_w_ready      PE array accepts the tile
//   pe_w_last       last tile of the current group (qualified by pe_w_valid)
//   tile_idx        index of the tile on pe_w_data within its group
//   we_done         one-cycle pulse: all groups delivered
//   busy            high whenever the controller is not idle
//   err_kernel      sticky: start seen with an unsupported kernel
// -----------------------------------------------------------------------------
module w_tile_fetch #(
   parameter int ROW_WIDTH    = 10,
   parameter int COLUMN_WIDTH = 9,
   parameter int DATA_WIDTH   = 16,
   parameter int RETRY_GAP    = 4
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        sudo_reset,
   input  logic                                        start,
   input  logic [2:0]                                  kernel,
   input  logic [7:0]                                  num_groups,
   output logic                                        weight_read,
   input  logic [COLUMN_WIDTH*DATA_WIDTH*ROW_WIDTH-1:0] weight_data,
   input  logic                                        weight_valid,
   output logic                                        we_valid_del,
   output logic [COLUMN_WIDTH*DATA_WIDTH*ROW_WIDTH-1:0] pe_w_data,
   output logic                                        pe_w_valid,
   input  logic                                        pe_w_ready,
   output logic                                        pe_w_last,
   output logic [1:0]                                  tile_idx,
   output logic                                        we_done,
   output logic                                        busy,
   output logic                                        err_kernel
);

   localparam int RETRY_W = $clog2(RETRY_GAP);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_REQ,
      S_REQ_WAIT,
      S_HOLD,
      S_DEL,
      S_DONE
   } state_t;

   state_t             state;
   logic [2:0]         kernel_q;
   logic [1:0]         last_tile;   // tiles_per_group - 1
   logic [7:0]         groups;
   logic [7:0]         group_cnt;
   logic [RETRY_W-1:0] retry_cnt;

   // Every output is a register; the one-cycle pulses are raised on the
   // transition into the state that owns them and dropped by default.
   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others, whatever the order
   // of the statements below.
   always_ff @(posedge clk) begin
      if (reset || sudo_reset) begin
         state        <= S_IDLE;
         kernel_q     <= '0;
         last_tile    <= '0;
         groups       <= '0;
         group_cnt    <= '0;
         retry_cnt    <= '0;
         weight_read  <= 1'b0;
         we_valid_del <= 1'b0;
         pe_w_data    <= '0;
         pe_w_valid   <= 1'b0;
         pe_w_last    <= 1'b0;
         tile_idx     <= '0;
         we_done      <= 1'b0;
         busy         <= 1'b0;
         err_kernel   <= 1'b0;
      end else begin
         weight_read  <= 1'b0;
         we_valid_del <= 1'b0;
         we_done      <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  kernel_q   <= kernel;
                  last_tile  <= (kernel == 3'd6) ? 2'd3 : 2'd0;
                  groups     <= (num_groups == 8'd0) ? 8'd1 : num_groups;
                  group_cnt  <= '0;
                  tile_idx   <= '0;
                  err_kernel <= 1'b0;
                  busy       <= 1'b1;
                  state      <= S_CHECK;
               end
            end

            S_CHECK: begin
               if (kernel_q == 3'd3 || kernel_q == 3'd6) begin
                  weight_read <= 1'b1;
                  state       <= S_REQ;
               end else begin
                  err_kernel <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_IDLE;
               end
            end

            // weight_read is high for exactly this cycle.
            S_REQ: begin
               retry_cnt <= '0;
               state     <= S_REQ_WAIT;
            end

            // Only answers arriving here are captured; a retry is the only
            // way a second read can be issued, so at most one is in flight.
            S_REQ_WAIT: begin
               if (weight_valid) begin
                  pe_w_data  <= weight_data;
                  pe_w_valid <= 1'b1;
                  pe_w_last  <= (tile_idx == last_tile);
                  state      <= S_HOLD;
               end else if (retry_cnt == RETRY_W'(RETRY_GAP - 1)) begin
                  weight_read <= 1'b1;
                  state       <= S_REQ;
               end else begin
                  retry_cnt <= retry_cnt + 1'b1;
               end
            end

            // pe_w_valid is always high here, so ready alone marks a transfer.
            S_HOLD: begin
               if (pe_w_ready) begin
                  pe_w_valid <= 1'b0;
                  pe_w_last  <= 1'b0;
                  if (pe_w_last) begin
                     we_valid_del <= 1'b1;
                     state        <= S_DEL;
                  end else begin
                     tile_idx    <= tile_idx + 2'd1;
                     weight_read <= 1'b1;
                     state       <= S_REQ;
                  end
               end
            end

            // group_cnt never exceeds groups-1 before this compare, so the
            // 8-bit increment cannot wrap even for 255 groups.
            S_DEL: begin
               tile_idx  <= '0;
               group_cnt <= group_cnt + 8'd1;
               if (group_cnt + 8'd1 == groups) begin
                  we_done <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  weight_read <= 1'b1;
                  state       <= S_REQ;
               end
            end

            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_w_tile_fetch.sv
// -----------------------------------------------------------------------------
// tb_w_tile_fetch
//   Drives w_tile_fetch with a slice-buffer responder (answers one cycle after
//   each read, optionally ignoring reads or injecting stray weight_valid) and a
//   PE-side consumer with random/stalled ready. A transaction-level model
//   tracks which tile must be on the bus, its index within the group, and how
//   many reads, tiles, group releases and completions each run must produce.
// -----------------------------------------------------------------------------
module tb_w_tile_fetch;

   localparam int RW  = 10;
   localparam int CW  = 9;
   localparam int DW  = 16;
   localparam int GAP = 4;
   localparam int TW  = CW * DW * RW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          sudo_reset = 1'b0;
   logic          start = 1'b0;
   logic [2:0]    kernel = '0;
   logic [7:0]    num_groups = '0;
   logic          weight_read;
   logic [TW-1:0] weight_data = '0;
   logic          weight_valid = 1'b0;
   logic          we_valid_del;
   logic [TW-1:0] pe_w_data;
   logic          pe_w_valid;
   logic          pe_w_ready = 1'b0;
   logic          pe_w_last;
   logic [1:0]    tile_idx;
   logic          we_done;
   logic          busy;
   logic          err_kernel;

   w_tile_fetch #(
      .ROW_WIDTH   (RW),
      .COLUMN_WIDTH(CW),
      .DATA_WIDTH  (DW),
      .RETRY_GAP   (GAP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sudo_reset  (sudo_reset),
      .start       (start),
      .kernel      (kernel),
      .num_groups  (num_groups),
      .weight_read (weight_read),
      .weight_data (weight_data),
      .weight_valid(weight_valid),
      .we_valid_del(we_valid_del),
      .pe_w_data   (pe_w_data),
      .pe_w_valid  (pe_w_valid),
      .pe_w_ready  (pe_w_ready),
      .pe_w_last   (pe_w_last),
      .tile_idx    (tile_idx),
      .we_done     (we_done),
      .busy        (busy),
      .err_kernel  (err_kernel)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // environment knobs
   int ready_pct   = 100;
   int drop_pct    = 0;
   int junk_pct    = 0;
   int ignore_reads = 0;
   int stall_left  = 0;

   // slice responder / model state
   bit            pend = 0;
   logic [TW-1:0] pend_data = '0;
   logic [TW-1:0] last_sent = '0;
   bit            seen_valid = 0;
   int            last_read_cyc = -1;
   bit            prev_valid = 0, prev_ready = 0, prev_read = 0;
   logic [TW-1:0] prev_data = '0;
   int            m_idx = 0, m_tpg = 1, m_groups = 1, pend_del = 0;
   int            n_reads = 0, n_tiles = 0, n_dels = 0, n_dones = 0;
   int            b_reads = 0, b_tiles = 0, b_dels = 0, b_dones = 0;

   task automatic check(input string name, input bit ok,
                        input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [TW-1:0] rand_word();
      logic [TW-1:0] w = '0;
      for (int i = 0; i < TW / 32 + 1; i++) w = {w[TW-33:0], 32'($urandom)};
      return w;
   endfunction

   task automatic mon_clear();
      prev_valid = 0; prev_ready = 0; prev_read = 0;
      pend = 0; seen_valid = 0; last_read_cyc = -1;
      pend_del = 0; m_idx = 0;
   endtask

   // Checks the sampled outputs against the model for the current cycle.
   task automatic monitor();
      if (prev_valid && !prev_ready) begin
         check("hold_valid", pe_w_valid == 1'b1, 64'(pe_w_valid), 64'd1);
         check("hold_data", pe_w_data === prev_data, pe_w_data[63:0], prev_data[63:0]);
      end
      if (weight_read) begin
         n_reads++;
         check("read_during_hold", !pe_w_valid, 64'(pe_w_valid), 64'd0);
         check("read_one_cycle", !prev_read, 64'(prev_read), 64'd0);
         if (last_read_cyc >= 0 && !seen_valid)
            check("retry_gap", cyc - last_read_cyc == GAP + 1, 64'(cyc - last_read_cyc), 64'(GAP + 1));
         last_read_cyc = cyc;
         seen_valid = 0;
      end
      check("last_needs_valid", !(pe_w_last && !pe_w_valid), 64'(pe_w_last), 64'd0);
      if (pe_w_valid && pe_w_ready) begin
         n_tiles++;
         check("tile_data", pe_w_data === last_sent, pe_w_data[63:0], last_sent[63:0]);
         check("tile_idx", tile_idx == 2'(m_idx), 64'(tile_idx), 64'(m_idx));
         check("tile_last", pe_w_last == (m_idx == m_tpg - 1), 64'(pe_w_last), 64'(m_idx == m_tpg - 1));
         if (m_idx == m_tpg - 1) begin
            pend_del++;
            m_idx = 0;
         end else begin
            m_idx++;
         end
      end
      if (we_valid_del) begin
         n_dels++;
         check("del_after_last", pend_del > 0, 64'(pend_del), 64'd1);
         if (pend_del > 0) pend_del--;
      end
      if (we_done) begin
         n_dones++;
         check("done_groups", n_dels - b_dels == m_groups, 64'(n_dels - b_dels), 64'(m_groups));
      end
      prev_valid = pe_w_valid;
      prev_ready = pe_w_ready;
      prev_data  = pe_w_data;
      prev_read  = weight_read;
   endtask

   // One clock: drive the slice answer and ready just after the rising edge,
   // check outputs on the falling edge, then decide the answer to any read.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (pend) begin
         weight_valid = 1'b1;
         weight_data  = pend_data;
         last_sent    = pend_data;
         seen_valid   = 1;
      end else if (pe_w_valid && $urandom_range(99) < junk_pct) begin
         weight_valid = 1'b1;   // stray answer while a tile is held: must be ignored
         weight_data  = rand_word();
      end else begin
         weight_valid = 1'b0;
         weight_data  = rand_word();
      end
      pend = 0;
      if (pe_w_valid && stall_left > 0) begin
         pe_w_ready = 1'b0;
         stall_left--;
      end else begin
         pe_w_ready = ($urandom_range(99) < ready_pct);
      end
      @(negedge clk);
      monitor();
      if (weight_read) begin
         if (ignore_reads > 0) ignore_reads--;
         else if ($urandom_range(99) >= drop_pct) begin
            pend = 1;
            pend_data = rand_word();
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      logic [9:0] ctrl;
      ctrl = {weight_read, we_valid_del, pe_w_valid, pe_w_last, tile_idx, we_done, busy, err_kernel, 1'b0};
      check({tag, "_ctrl_zero"}, ctrl == '0, 64'(ctrl), 64'd0);
      check({tag, "_data_zero"}, pe_w_data == '0, pe_w_data[63:0], 64'd0);
   endtask

   task automatic begin_run(input logic [2:0] k, input logic [7:0] ng);
      m_tpg = (k == 3'd6) ? 4 : 1;
      m_groups = (ng == 8'd0) ? 1 : int'(ng);
      m_idx = 0; pend_del = 0; last_read_cyc = -1; seen_valid = 0;
      b_reads = n_reads; b_tiles = n_tiles; b_dels = n_dels; b_dones = n_dones;
      kernel = k;
      num_groups = ng;
      start = 1'b1;
   endtask

   // Runs a started sequence to completion and checks its totals.
   task automatic finish_run(input int budget, input bit probe_start);
      int lat = -1;
      bit done = 0;
      for (int i = 1; i <= budget && !done; i++) begin
         step();
         if (i == 1) begin
            check("err_cleared_on_start", err_kernel == 1'b0, 64'(err_kernel), 64'd0);
            kernel = 3'($urandom);
            num_groups = 8'($urandom);
         end
         if (weight_read && lat < 0) lat = i;
         if (we_done) done = 1;
         start = (probe_start && i == 7 && !done);
      end
      start = 1'b0;
      check("done_seen", done, 64'(done), 64'd1);
      step();
      check("idle_after_done", busy == 1'b0, 64'(busy), 64'd0);
      check("first_read_latency", lat == 2, 64'(lat), 64'd2);
      check("tile_count", n_tiles - b_tiles == m_groups * m_tpg, 64'(n_tiles - b_tiles), 64'(m_groups * m_tpg));
      check("del_count", n_dels - b_dels == m_groups, 64'(n_dels - b_dels), 64'(m_groups));
      check("done_count", n_dones - b_dones == 1, 64'(n_dones - b_dones), 64'd1);
      check("no_err", err_kernel == 1'b0, 64'(err_kernel), 64'd0);
   endtask

   initial begin
      // reset
      reset = 1'b1;
      mon_clear();
      step();
      step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // kernel 3, two groups, immediate answers, ready held high
      ready_pct = 100; drop_pct = 0; junk_pct = 0;
      begin_run(3'd3, 8'd2);
      finish_run(200, 0);
      check("k3_reads", n_reads - b_reads == 2, 64'(n_reads - b_reads), 64'd2);

      // kernel 6, one group: tiles 0..3, last only on tile 3
      begin_run(3'd6, 8'd1);
      finish_run(200, 0);
      check("k6_reads", n_reads - b_reads == 4, 64'(n_reads - b_reads), 64'd4);

      // first two reads go unanswered: re-pulses, still exactly four tiles
      ignore_reads = 2;
      begin_run(3'd6, 8'd1);
      finish_run(300, 0);
      check("retry_reads", n_reads - b_reads == 6, 64'(n_reads - b_reads), 64'd6);

      // PE stalls five cycles on the held tile
      stall_left = 5; junk_pct = 50;
      begin_run(3'd3, 8'd1);
      finish_run(200, 0);
      check("stall_reads", n_reads - b_reads == 1, 64'(n_reads - b_reads), 64'd1);
      junk_pct = 0;

      // unsupported kernel
      b_reads = n_reads;
      kernel = 3'd1; num_groups = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      check("err_busy_in_check", busy == 1'b1, 64'(busy), 64'd1);
      step();
      check("err_busy_low", busy == 1'b0, 64'(busy), 64'd0);
      check("err_set", err_kernel == 1'b1, 64'(err_kernel), 64'd1);
      repeat (3) step();
      check("err_sticky", err_kernel == 1'b1, 64'(err_kernel), 64'd1);
      check("err_no_read", n_reads == b_reads, 64'(n_reads - b_reads), 64'd0);
      begin_run(3'd3, 8'd1);
      finish_run(200, 0);

      // soft clear while tile 2 of a kernel-6 group is held
      stall_left = 100;
      begin_run(3'd6, 8'd1);
      for (int i = 0; i < 300 && !(pe_w_valid && tile_idx == 2'd2); i++) begin
         step();
         start = 1'b0;
      end
      check("reach_tile2", pe_w_valid && tile_idx == 2'd2, 64'(tile_idx), 64'd2);
      stall_left = 0;
      sudo_reset = 1'b1;
      mon_clear();
      step();
      sudo_reset = 1'b0;
      check_all_zero("sudo");
      b_dones = n_dones; b_dels = n_dels;
      repeat (5) step();
      check("sudo_no_done", n_dones == b_dones, 64'(n_dones - b_dones), 64'd0);
      check("sudo_no_del", n_dels == b_dels, 64'(n_dels - b_dels), 64'd0);
      begin_run(3'd6, 8'd1);
      finish_run(200, 0);

      // num_groups 0 behaves as one group
      begin_run(3'd3, 8'd0);
      finish_run(200, 0);

      // randomized runs: drops, stray answers, random ready, start while busy
      ready_pct = 60; drop_pct = 25; junk_pct = 30;
      for (int r = 0; r < 10; r++) begin
         begin_run(($urandom_range(1) != 0) ? 3'd6 : 3'd3, 8'($urandom_range(4, 1)));
         finish_run(4000, 1);
      end

      // 255 groups complete without counter wrap
      ready_pct = 100; drop_pct = 0; junk_pct = 0;
      begin_run(3'd3, 8'd255);
      finish_run(3000, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
